// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

  typedef enum logic [1:0] {LOAD, CHECK, RUN, ERR} load_state_e;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Smallest address width able to index the given number of words.
  function automatic int unsigned addr_w_for(input int unsigned cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser plus mid-bit sampling state machine.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state_q;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       byte_q;
  logic             valid_q, ferr_q, busy_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RX_IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (rx_prev_q == STOP_BIT && rx_sync_q == START_BIT) begin
            state_q <= RX_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        // A start bit that is gone by mid-bit is treated as a glitch.
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (rx_sync_q == START_BIT) begin
              state_q   <= RX_DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            busy_q  <= 1'b0;
            if (rx_sync_q == STOP_BIT) begin
              valid_q <= 1'b1;
              byte_q  <= shift_q;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_valid  = valid_q;
  assign rx_byte   = byte_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes into instruction words, writes imem, checks
// an optional trailing checksum and then releases the CPU from reset.
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned CELL_NUMBERS = 64,
  parameter int unsigned ADDR_W       = addr_w_for(CELL_NUMBERS),
  parameter int unsigned BIG_ENDIAN   = 0,
  parameter int unsigned CHECKSUM_EN  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rx,
  input  logic                    reload,
  output logic                    imem_we,
  output logic [ADDR_W-1:0]       imem_addr,
  output logic [8*WORD_BYTES-1:0] imem_wdata,
  output logic                    cpu_rst,
  output logic                    load_done,
  output logic                    load_err
);

  localparam int unsigned DATA_W = 8 * WORD_BYTES;
  localparam int unsigned BI_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELL_NUMBERS - 1);

  logic       rx_valid, frame_err, rx_busy;
  logic [7:0] rx_byte;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uart_rx),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  load_state_e       state_q;
  logic [BI_W-1:0]   byte_idx_q;
  logic [DATA_W-1:0] word_q, word_d, wdata_q;
  logic [7:0]        sum_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q, cpu_rst_q, done_q, err_q, drop_q;
  logic [BI_W-1:0]   lane;
  logic              rx_take, ferr_take, restart;

  // A frame already in flight when reload arrives is swallowed.
  assign rx_take   = rx_valid && !drop_q;
  assign ferr_take = frame_err && !drop_q;
  assign restart   = reload && (state_q == RUN || state_q == ERR);

  always_comb begin
    word_d = word_q;
    lane   = (BIG_ENDIAN != 0) ? (LAST_BYTE - byte_idx_q) : byte_idx_q;
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      if (BI_W'(i) == lane) word_d[i*8 +: 8] = rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      state_q    <= LOAD;
      byte_idx_q <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= rst && rx_busy;
    end else begin
      we_q <= 1'b0;
      if (drop_q && (rx_valid || frame_err || !rx_busy)) drop_q <= 1'b0;
      if (we_q && addr_q != LAST_ADDR) addr_q <= addr_q + ADDR_W'(1);
      case (state_q)
        LOAD: begin
          if (ferr_take) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (rx_take) begin
            word_q <= word_d;
            sum_q  <= sum_q + rx_byte;
            if (byte_idx_q == LAST_BYTE) begin
              byte_idx_q <= '0;
              we_q       <= 1'b1;
              wdata_q    <= word_d;
              if (addr_q == LAST_ADDR) begin
                if (CHECKSUM_EN != 0) begin
                  state_q <= CHECK;
                end else begin
                  state_q   <= RUN;
                  cpu_rst_q <= 1'b0;
                  done_q    <= 1'b1;
                end
              end
            end else begin
              byte_idx_q <= byte_idx_q + BI_W'(1);
            end
          end
        end
        CHECK: begin
          if (ferr_take || (rx_take && rx_byte != sum_q)) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (rx_take) begin
            state_q   <= RUN;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench: little- and big-endian loaders share one serial line.
module tb_uart_imem_loader;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        rst, uart_rx, reload;
  logic        we_le, we_be, cpu_rst_le, cpu_rst_be, done_le, done_be, err_le, err_be;
  logic [0:0]  addr_le, addr_be;
  logic [31:0] wdata_le, wdata_be;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_le [2];
  logic [31:0] mem_be [2];
  logic [0:0]  alog_le [256];
  int wr_le = 0, wr_be = 0, base_le, base_be;

  always #5 clk = ~clk;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(4), .CELL_NUMBERS(2),
                     .BIG_ENDIAN(0), .CHECKSUM_EN(1)) dut_le (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .reload(reload),
    .imem_we(we_le), .imem_addr(addr_le), .imem_wdata(wdata_le),
    .cpu_rst(cpu_rst_le), .load_done(done_le), .load_err(err_le));

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(4), .CELL_NUMBERS(2),
                     .BIG_ENDIAN(1), .CHECKSUM_EN(1)) dut_be (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .reload(reload),
    .imem_we(we_be), .imem_addr(addr_be), .imem_wdata(wdata_be),
    .cpu_rst(cpu_rst_be), .load_done(done_be), .load_err(err_be));

  // Write capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (we_le) begin
      mem_le[addr_le] = wdata_le;
      alog_le[wr_le[7:0]] = addr_le;
      wr_le++;
    end
    if (we_be) begin
      mem_be[addr_be] = wdata_be;
      wr_be++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Bytes go out least-significant byte of 'img' first.
  task automatic send_image(input logic [63:0] img, input logic [7:0] csum);
    for (int i = 0; i < 8; i++) send_byte(img[8*i +: 8], 1'b1);
    send_byte(csum, 1'b1);
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [7:0] sum8(input logic [63:0] img);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 8; i++) s = s + img[8*i +: 8];
    return s;
  endfunction

  task automatic snap();
    base_le = wr_le;
    base_be = wr_be;
  endtask

  localparam logic [63:0] IMG_A = 64'h0000_02B7_0000_0537;
  localparam logic [63:0] IMG_B = 64'h0000_0013_0000_0013;

  initial begin
    rst = 1'b0; reload = 1'b0; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_we",      32'(we_le),      32'd0);
    check_eq("rst_addr",    32'(addr_le),    32'd0);
    check_eq("rst_wdata",   wdata_le,        32'd0);
    check_eq("rst_cpu_rst", 32'(cpu_rst_le), 32'd1);
    check_eq("rst_done",    32'(done_le),    32'd0);
    check_eq("rst_err",     32'(err_le),     32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Nominal image; checksum 37+05+B7+02 = F5.
    snap();
    check_eq("csum_a", 32'(sum8(IMG_A)), 32'h0000_00F5);
    send_image(IMG_A, sum8(IMG_A));
    check_eq("nom_writes",   32'(wr_le - base_le), 32'd2);
    check_eq("nom_le_w0",    mem_le[0], 32'h0000_0537);
    check_eq("nom_le_w1",    mem_le[1], 32'h0000_02B7);
    check_eq("nom_be_w0",    mem_be[0], 32'h3705_0000);
    check_eq("nom_be_w1",    mem_be[1], 32'hB702_0000);
    check_eq("nom_done_le",  32'(done_le),    32'd1);
    check_eq("nom_done_be",  32'(done_be),    32'd1);
    check_eq("nom_cpu_rst",  32'(cpu_rst_le), 32'd0);
    check_eq("nom_err",      32'(err_le),     32'd0);
    send_byte(8'h55, 1'b1);
    check_eq("run_ignore",   32'(wr_le - base_le), 32'd2);

    // Reload from RUN, second image with checksum 26.
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check_eq("reload_cpu_rst", 32'(cpu_rst_le), 32'd1);
    check_eq("reload_done",    32'(done_le),    32'd0);
    snap();
    send_image(IMG_B, 8'h26);
    check_eq("rl_writes",  32'(wr_be - base_be), 32'd2);
    check_eq("rl_le_w0",   mem_le[0], 32'h0000_0013);
    check_eq("rl_le_w1",   mem_le[1], 32'h0000_0013);
    check_eq("rl_be_w1",   mem_be[1], 32'h1300_0000);
    check_eq("rl_done",    32'(done_le), 32'd1);

    // Bad checksum: words land, loader parks in ERR.
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    snap();
    send_image(IMG_A, sum8(IMG_A) - 8'd1);
    check_eq("bad_writes",  32'(wr_le - base_le), 32'd2);
    check_eq("bad_err",     32'(err_le),     32'd1);
    check_eq("bad_cpu_rst", 32'(cpu_rst_le), 32'd1);
    check_eq("bad_done",    32'(done_le),    32'd0);

    // Reload from ERR, then a framing error on the third byte.
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check_eq("reload_err_clr", 32'(err_le), 32'd0);
    snap();
    send_byte(8'h37, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("ferr_err",    32'(err_le), 32'd1);
    check_eq("ferr_err_be", 32'(err_be), 32'd1);
    check_eq("ferr_nowr",   32'(wr_le - base_le), 32'd0);
    for (int i = 3; i < 8; i++) send_byte(IMG_A[8*i +: 8], 1'b1);
    send_byte(sum8(IMG_A), 1'b1);
    check_eq("ferr_nowr_after", 32'(wr_le - base_le), 32'd0);
    check_eq("ferr_cpu_rst",    32'(cpu_rst_le), 32'd1);

    // Reset part-way through an image; the next image starts over at 0.
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    send_byte(8'hEE, 1'b1);
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    snap();
    send_image(IMG_A, sum8(IMG_A));
    check_eq("mid_writes",    32'(wr_le - base_le), 32'd2);
    check_eq("mid_first_adr", 32'(alog_le[base_le[7:0]]), 32'd0);
    check_eq("mid_le_w0",     mem_le[0], 32'h0000_0537);
    check_eq("mid_le_w1",     mem_le[1], 32'h0000_02B7);
    check_eq("mid_done",      32'(done_le), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
